// File: rtl/alu_sequencer.sv
// alu_sequencer: loads A, B and OP words from one valid/ready stream, drives them
// into a combinational ALU, registers the result and offers it on a valid/ready stream.
// Optional opcode validation is enabled by defining ALU_OPCODE_CHECK_EN.
module alu_sequencer #(
    parameter int unsigned NB_DATA = 6,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_in_data,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic               i_clear,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA:0]   i_alu_res,
    output logic [NB_DATA:0]   o_res_data,
    output logic               o_res_err,
    output logic               o_res_valid,
    input  logic               i_res_ready
);

    typedef enum logic [2:0] {StWaitA, StWaitB, StWaitOp, StExec, StHold} state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA:0]   res_data_q, res_data_d;
    logic               in_ready;
    logic               accept;

`ifdef ALU_OPCODE_CHECK_EN
    localparam logic [NB_OP-1:0] OpAdd = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OpSub = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OpAnd = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OpOr  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OpXor = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OpSra = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OpSrl = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OpNor = NB_OP'(6'b100111);

    logic res_err_q, res_err_d;

    function automatic logic op_supported(input logic [NB_OP-1:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSra, OpSrl, OpNor: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Next-state and datapath-load decisions for the load/execute/hold sequence.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
`ifdef ALU_OPCODE_CHECK_EN
        res_err_d  = res_err_q;
`endif
        in_ready   = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            StWaitA, StWaitB, StWaitOp: begin
                in_ready = 1'b1;
                accept   = i_in_valid & ~i_clear;
                // Clear wins over a same-cycle handshake: the word is dropped.
                if (i_clear) begin
                    state_d = StWaitA;
                end else if (accept) begin
                    unique case (state_q)
                        StWaitA: begin
                            alu_a_d = i_in_data;
                            state_d = StWaitB;
                        end
                        StWaitB: begin
                            alu_b_d = i_in_data;
                            state_d = StWaitOp;
                        end
                        default: begin
                            alu_op_d = i_in_data[NB_OP-1:0];
                            state_d  = StExec;
                        end
                    endcase
                end
            end
            StExec: begin
`ifdef ALU_OPCODE_CHECK_EN
                if (op_supported(alu_op_q)) begin
                    res_data_d = i_alu_res;
                    res_err_d  = 1'b0;
                end else begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end
`else
                res_data_d = i_alu_res;
`endif
                state_d = StHold;
            end
            StHold: begin
                if (i_res_ready) begin
                    state_d = StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    // State and datapath registers; reset drops any pending result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StWaitA;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
`ifdef ALU_OPCODE_CHECK_EN
            res_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
`ifdef ALU_OPCODE_CHECK_EN
            res_err_q  <= res_err_d;
`endif
        end
    end

    assign o_in_ready  = in_ready;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_res_data  = res_data_q;
    assign o_res_valid = (state_q == StHold);
`ifdef ALU_OPCODE_CHECK_EN
    assign o_res_err   = res_err_q;
`else
    assign o_res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed scenarios plus randomized traffic, with a
// scoreboard queue fed by the stimulus side and drained by an independent monitor.
// Honours ALU_OPCODE_CHECK_EN to match the RTL build.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic [5:0] alu_op;
    logic [6:0] alu_res;
    logic [6:0] res_data;
    logic       res_err;
    logic       res_valid;
    logic       res_ready;

    int checks = 0;
    int errors = 0;

    logic [5:0] words[$];
    logic [7:0] exp_q[$];   // {err, data}
    logic [5:0] ops[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b000011, 6'b000010, 6'b100111};

    always #5 clk = ~clk;

    alu_sequencer #(.NB_DATA(6), .NB_OP(6)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_clear     (clear),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .i_alu_res   (alu_res),
        .o_res_data  (res_data),
        .o_res_err   (res_err),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready)
    );

    // Behavioural ALU: signed operands, result one bit wider.
    function automatic logic [6:0] alu_f(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] op);
        int sa = $signed(a);
        int sb = $signed(b);
        case (op)
            6'b100000: return 7'(sa + sb);
            6'b100010: return 7'(sa - sb);
            6'b100100: return 7'(sa & sb);
            6'b100101: return 7'(sa | sb);
            6'b100110: return 7'(sa ^ sb);
            6'b100111: return 7'(~(sa | sb));
            6'b000011: return 7'(sa >>> b);
            6'b000010: return 7'(int'(a) >> b);
            default:   return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb alu_res = alu_f(alu_a, alu_b, alu_op);

    function automatic logic [7:0] expect_f(input logic [5:0] a, input logic [5:0] b,
                                            input logic [5:0] op);
        logic ok = 1'b0;
        foreach (ops[i]) if (ops[i] == op) ok = 1'b1;
`ifdef ALU_OPCODE_CHECK_EN
        if (!ok) return 8'h80;
`else
        if (!ok) return {1'b0, alu_f(a, b, op)};
`endif
        return {1'b0, alu_f(a, b, op)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [5:0] w);
        words.push_back(w);
        if (words.size() == 3) begin
            exp_q.push_back(expect_f(words[0], words[1], words[2]));
            words.delete();
        end
    endtask

    // Present one word and hold it until the handshake; starts/ends just after posedge.
    task automatic send(input logic [5:0] w);
        bit done = 0;
        in_data  = w;
        in_valid = 1'b1;
        clear    = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(w);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    // Monitor: compares every result handshake against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {25'd0, res_err, res_data}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("result_data", 32'(res_data), 32'(e[6:0]));
                    check("result_err", 32'(res_err), 32'(e[7]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; clear = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_alu", {14'd0, alu_a, alu_b, alu_op}, 0);
        check("rst_res", {24'd0, res_err, res_data}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: 5 + 3, latency and registered operands
        send(6'd5); send(6'd3); send(6'b100000);
        @(negedge clk);
        check("t1_exec_valid", 32'(res_valid), 0);
        check("t1_exec_in_ready", 32'(in_ready), 0);
        check("t1_alu_a", 32'(alu_a), 5);
        check("t1_alu_b", 32'(alu_b), 3);
        @(negedge clk);
        check("t1_hold_valid", 32'(res_valid), 1);
        check("t1_data", 32'(res_data), 8);
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1;

        // 2: -32 - 1
        send(6'b100000); send(6'd1); send(6'b100010);
        @(negedge clk); @(negedge clk);
        check("t2_data", 32'(res_data), 32'(7'b1011111));
        check("t2_err", 32'(res_err), 0);
        @(posedge clk); #1;

        // 3: SRA with backpressure
        res_ready = 1'b0;
        send(6'b100100); send(6'd1); send(6'b000011);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_valid_held", 32'(res_valid), 1);
            check("t3_data_stable", 32'(res_data), 32'(7'b1110010));
            check("t3_in_ready_low", 32'(in_ready), 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1;

        // 4: clear together with a valid B word
        send(6'd7);
        in_data = 6'd9; in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        if (in_ready) words.delete();
        @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t4_a_loaded", 32'(alu_a), 7);
        check("t4_b_unchanged", 32'(alu_b), 1);
        @(posedge clk); #1;
        send(6'd2); send(6'd2); send(6'b100000);
        @(negedge clk); @(negedge clk);
        check("t4_data", 32'(res_data), 4);
        check("t4_alu_a", 32'(alu_a), 2);
        @(posedge clk); #1;

        // 5: reset while holding a result
        res_ready = 1'b0;
        send(6'd1); send(6'd2); send(6'b100000);
        @(negedge clk); @(negedge clk);
        check("t5_hold_valid", 32'(res_valid), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete(); words.delete();
        @(negedge clk);
        check("t5_valid_dropped", 32'(res_valid), 0);
        check("t5_alu_cleared", {14'd0, alu_a, alu_b, alu_op}, 0);
        check("t5_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1 res_ready = 1'b1;

        // 6: unsupported opcode
        send(6'd1); send(6'd2); send(6'b111111);
        @(negedge clk); @(negedge clk);
`ifdef ALU_OPCODE_CHECK_EN
        check("t6_err", 32'(res_err), 1);
        check("t6_data", 32'(res_data), 0);
`else
        check("t6_err", 32'(res_err), 0);
        check("t6_data", 32'(res_data), 3);
`endif
        @(posedge clk); #1;

        // Random traffic with clears and backpressure
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 15) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            if (words.size() == 2 && $urandom_range(0, 3) != 0) in_data = ops[$urandom_range(0, 7)];
            else in_data = 6'($urandom);
            @(negedge clk);
            if (in_ready) begin
                if (clear) words.delete();
                else if (in_valid) model_accept(in_data);
            end
            @(posedge clk); #1;
        end

        in_valid = 1'b0; clear = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
